fifo_drain_sched: RTL and testbench
===================================

Name: fifo_drain_sched

Overview:
- Schedules which of the N per-block capture FIFOs is drained into the Ethernet read-out path. Only one FIFO can feed the read-out at a time.
- Grants FIFOs round-robin among those signalling fifo_req. Also force-flushes partially filled FIFOs after an idle timeout.
- Bounds each frame to BURST words, latches overflow events per channel and supplies the frame sequence number.
- Sits between the block array and read_out, in the mii_clk domain.

Parameters:
- N, 24, number of requesting FIFOs (channels 1..N).
- BURST, 64, maximum words drained per frame; legal range 1..255.
- FLUSH_CYCLES, 1000000, idle cycles before non-empty FIFOs are scheduled without fifo_req.

Ports:
- clk  in  1  mii_clk domain clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; 0 blocks new arbitration, current frame completes.
- fifo_req  in  N  FIFO at or above drain threshold.
- fifo_empty  in  N  FIFO empty.
- fifo_oflow  in  N  FIFO overflow event, any-cycle pulse or level.
- tx_busy  in  1  read-out framer busy.
- tx_word_done  in  1  one-cycle pulse per word consumed from the granted FIFO.
- grant  out  N  one-hot read select; all-zero when no frame is active.
- tx_chan  out  5  granted channel index, 1..N; 0 when idle.
- tx_start  out  1  one-cycle frame start pulse.
- tx_last  out  1  one-cycle pulse: payload finished, framer appends trailer.
- tx_oflow  out  1  granted channel overflowed since its last frame; stable for the frame.
- seqnum  out  8  frame sequence number.

Behaviour:
- Reset (asynchronous, any state): state IDLE; grant, tx_chan, tx_start, tx_last, tx_oflow all 0; seqnum 0; rr pointer 0; oflow flags 0; flush counter 0; word count 0.
- Candidates: cand[i] = fifo_req[i] | (flush_due & !fifo_empty[i]).
- IDLE: if enable and any cand, go to ARB next cycle.
- ARB (1 cycle):
  - Pick the lowest-index candidate above the rr pointer; wrap to channel 1.
  - Latch tx_chan and the one-hot grant, registered to the next cycle.
  - Capture tx_oflow from that channel's flag and clear the flag.
  - If cand has vanished by ARB, return to IDLE with no outputs asserted.
- START: when tx_busy = 0, assert tx_start for 1 cycle, then go to DRAIN.
  - Minimum latency: cand seen in IDLE at cycle t gives tx_start at t+2.
- DRAIN: increment the 8-bit word count on each tx_word_done. On the pulse that makes count = BURST, or on a pulse with fifo_empty[chan] = 1, assert tx_last the next cycle and go to FINISH.
- DRAIN with fifo_empty[chan] = 1 before any word: assert tx_last immediately, giving an empty frame.
- FINISH: wait for tx_busy = 0. Then:
  - clear grant and tx_chan;
  - rr pointer := tx_chan;
  - seqnum += 1, wrapping 255 to 0;
  - word count := 0;
  - return to IDLE.
- Overflow flags:
  - flag[i] is set whenever fifo_oflow[i] = 1.
  - If set and clear hit flag[chan] in the same ARB cycle, set wins: the flag stays 1 and tx_oflow = 1.
- Flush timer:
  - Counts clk cycles, saturating at FLUSH_CYCLES.
  - Reset to 0 on every tx_start.
  - flush_due = (count == FLUSH_CYCLES).
- enable falling mid-frame: the frame runs to FINISH; no further ARB until enable = 1.
- grant never changes between ARB and the FINISH exit; at most one grant bit is 1.
- tx_word_done outside DRAIN is ignored.

Test Plan:
- Reqs on ch 3, 7, 24 held high, BURST = 4, tx_word_done every 2 cycles → frames in order 3, 7, 24, 3. Each frame has 4 word pulses and tx_last. seqnum reads 0, 1, 2, 3.
- Only ch 5 non-empty, no req, FLUSH_CYCLES = 100 → tx_start with tx_chan = 5 exactly 102 cycles after the last tx_start.
- Ch 2 granted, fifo_empty[2] rises after the 2nd word, BURST = 64 → tx_last the cycle after the 2nd tx_word_done. Next seqnum +1.
- fifo_oflow[9] pulse, then req[9] → tx_oflow = 1 for that frame and 0 for the next ch 9 frame. An oflow pulse coincident with ARB gives 1 in both frames.
- rst_n dropped mid-DRAIN on ch 11 → grant, tx_chan, tx_start, tx_last, tx_oflow and seqnum all 0 immediately, without waiting for a clock edge. After release, arbitration restarts from ch 1.
- enable = 0 during a frame, 256 frames run back to back → the current frame completes with no new tx_start while enable = 0. Across the 256 frames seqnum wraps 255 → 0.

Source files
------------

// File: rtl/fifo_drain_sched_if.sv
// Bundle between the capture FIFO array, the drain scheduler and the read-out framer.
// Pure wiring, zero latency.
// No backpressure of its own; the framer throttles through tx_busy and tx_word_done.
interface fifo_drain_sched_if #(
  parameter int N = 24
);
  logic         enable;
  logic [N-1:0] fifo_req;
  logic [N-1:0] fifo_empty;
  logic [N-1:0] fifo_oflow;
  logic         tx_busy;
  logic         tx_word_done;
  logic [N-1:0] grant;
  logic [4:0]   tx_chan;
  logic         tx_start;
  logic         tx_last;
  logic         tx_oflow;
  logic [7:0]   seqnum;

  // Scheduler side.
  modport master (
    input  enable, fifo_req, fifo_empty, fifo_oflow, tx_busy, tx_word_done,
    output grant, tx_chan, tx_start, tx_last, tx_oflow, seqnum
  );

  // FIFO array / framer side.
  modport slave (
    output enable, fifo_req, fifo_empty, fifo_oflow, tx_busy, tx_word_done,
    input  grant, tx_chan, tx_start, tx_last, tx_oflow, seqnum
  );
endinterface

// File: rtl/fifo_drain_sched.sv
// Round-robin drain scheduler: picks one capture FIFO per read-out frame, flushes idle data.
// Latency: candidate seen in IDLE at cycle t gives tx_start at t+2 (if framer idle).
// Backpressure: tx_start held off while tx_busy; frame close waits for tx_busy to drop.
module fifo_drain_sched #(
  parameter int N            = 24,
  parameter int BURST        = 64,
  parameter int FLUSH_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_drain_sched_if.master bus
);

  localparam int            CW        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CW-1:0] FLUSH_MAX = FLUSH_CYCLES[CW-1:0];
  localparam logic [7:0]    BURST_W   = BURST[7:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_START,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q;
  logic [4:0]    chan_q;
  logic          oflow_q;
  logic          last_q;
  logic [7:0]    seq_q;
  logic [4:0]    rr_q;
  logic [N-1:0]  flag_q;
  logic [CW-1:0] flush_q;
  logic [7:0]    wcnt_q;

  logic          flush_due;
  logic [N-1:0]  cand;
  logic          pick_vld;
  logic [N-1:0]  pick_oh;
  logic [4:0]    pick_chan;
  logic          grab_oflow;
  logic          cur_empty;
  logic          word;
  logic          drain_end;
  logic          do_grant;
  logic          do_finish;
  logic          do_last;
  logic          start_pulse;

  assign flush_due  = (flush_q == FLUSH_MAX);
  assign cand       = bus.fifo_req | ({N{flush_due}} & ~bus.fifo_empty);
  // An overflow arriving in the ARB cycle itself is reported in this frame too.
  assign grab_oflow = |((flag_q | bus.fifo_oflow) & pick_oh);
  // grant_q is one-hot, so masking selects the granted channel's empty flag.
  assign cur_empty  = |(bus.fifo_empty & grant_q);
  assign word       = (state_q == S_DRAIN) && bus.tx_word_done;
  // Close on the BURST-th word, on a word that empties the FIFO, or on an empty FIFO with no data.
  assign drain_end  = word ? ((wcnt_q + 8'd1 == BURST_W) || cur_empty)
                           : ((wcnt_q == 8'd0) && cur_empty);

  // Round-robin search: first candidate strictly after the last served channel, wrapping.
  always_comb begin
    pick_vld  = 1'b0;
    pick_oh   = '0;
    pick_chan = '0;
    for (int k = 0; k < N; k++) begin
      if (!pick_vld && cand[(int'(rr_q) + k) % N]) begin
        pick_vld                       = 1'b1;
        pick_oh[(int'(rr_q) + k) % N]  = 1'b1;
        pick_chan                      = 5'((int'(rr_q) + k) % N + 1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and control strobes.
  always_comb begin
    state_d     = state_q;
    do_grant    = 1'b0;
    do_finish   = 1'b0;
    do_last     = 1'b0;
    start_pulse = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.enable && (|cand)) state_d = S_ARB;
      end
      S_ARB: begin
        if (pick_vld) begin
          do_grant = 1'b1;
          state_d  = S_START;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_START: begin
        if (!bus.tx_busy) begin
          start_pulse = 1'b1;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_end) begin
          do_last = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        if (!bus.tx_busy) begin
          do_finish = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame datapath: grant/channel latch, word count, sequence number, overflow flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      chan_q  <= '0;
      oflow_q <= 1'b0;
      last_q  <= 1'b0;
      seq_q   <= '0;
      rr_q    <= '0;
      flag_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      // Set has priority over the ARB clear so a coincident overflow is never lost.
      flag_q <= (flag_q & ~({N{do_grant}} & pick_oh)) | bus.fifo_oflow;
      last_q <= do_last;
      if (do_grant) begin
        grant_q <= pick_oh;
        chan_q  <= pick_chan;
        oflow_q <= grab_oflow;
      end else if (do_finish) begin
        grant_q <= '0;
        chan_q  <= '0;
        oflow_q <= 1'b0;
        rr_q    <= chan_q;
        seq_q   <= seq_q + 8'd1;
        wcnt_q  <= '0;
      end else if (word) begin
        wcnt_q  <= wcnt_q + 8'd1;
      end
    end
  end

  // Idle timer: the tx_start cycle counts as cycle 0, saturates at FLUSH_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          flush_q <= '0;
    else if (start_pulse) flush_q <= CW'(1);
    else if (!flush_due)  flush_q <= flush_q + CW'(1);
  end

  assign bus.grant    = grant_q;
  assign bus.tx_chan  = chan_q;
  assign bus.tx_start = start_pulse;
  assign bus.tx_last  = last_q;
  assign bus.tx_oflow = oflow_q;
  assign bus.seqnum   = seq_q;

endmodule

// File: tb/tb_fifo_drain_sched.sv
// Scoreboard bench for fifo_drain_sched with N=24, BURST=4, FLUSH_CYCLES=100.
// Expected frames are queued when stimulus is applied and compared at tx_start / tx_last.
// Word pulses come from a free-running every-other-cycle generator or are driven by hand.
module tb_fifo_drain_sched;

  typedef struct {
    int chan;
    int oflow;
    int seq;
    int words;
  } exp_t;

  logic clk;
  logic rst_n;
  logic wd_auto;
  logic wd_gen;
  logic wd_man;

  int   n_chk;
  int   n_pass;
  int   cyc;
  int   exp_seq;
  int   frames_started;
  int   frames_done;
  int   bs;
  int   bd;
  exp_t sb[$];
  int   start_cyc[$];

  exp_t cur;
  int   in_frame;
  int   words;
  int   last_wd_cyc;

  fifo_drain_sched_if #(.N(24)) bus ();

  fifo_drain_sched #(.N(24), .BURST(4), .FLUSH_CYCLES(100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.tx_word_done = wd_auto ? wd_gen : wd_man;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    wd_gen = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      wd_gen = !wd_gen;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int chan, input int ofl, input int nw);
    exp_t e;
    e.chan  = chan;
    e.oflow = ofl;
    e.seq   = exp_seq;
    e.words = nw;
    sb.push_back(e);
    exp_seq = (exp_seq + 1) % 256;
  endtask

  task automatic wait_started(input int target, input int budget);
    int b;
    b = budget;
    while (frames_started < target && b > 0) begin
      tick();
      b--;
    end
    if (frames_started < target) chk("timeout_start", frames_started, target);
  endtask

  task automatic wait_done(input int target, input int budget);
    int b;
    b = budget;
    while (frames_done < target && b > 0) begin
      tick();
      b--;
    end
    if (frames_done < target) chk("timeout_done", frames_done, target);
  endtask

  // Frame monitor: pops the scoreboard at tx_start, checks word count at tx_last.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0;
    end else if (bus.tx_start) begin
      frames_started++;
      start_cyc.push_back(cyc);
      chk("sb_has_entry", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        cur = sb.pop_front();
        chk("tx_chan", 32'(bus.tx_chan), cur.chan);
        chk("tx_oflow", 32'(bus.tx_oflow), cur.oflow);
        chk("seqnum", 32'(bus.seqnum), cur.seq);
        chk("grant_start", 32'(bus.grant), 32'd1 << (cur.chan - 1));
      end
      in_frame    = 1;
      words       = 0;
      last_wd_cyc = -100;
    end else if (bus.tx_last) begin
      chk("last_in_frame", in_frame, 1);
      chk("words", words, cur.words);
      chk("grant_last", 32'(bus.grant), 32'd1 << (cur.chan - 1));
      if (cur.words > 0) chk("last_after_word", cyc - last_wd_cyc, 1);
      in_frame = 0;
      frames_done++;
    end else if (in_frame != 0 && bus.tx_word_done) begin
      words++;
      last_wd_cyc = cyc;
    end
  end

  initial begin
    n_chk = 0; n_pass = 0; exp_seq = 0;
    frames_started = 0; frames_done = 0; in_frame = 0;
    rst_n = 1'b0;
    wd_auto = 1'b0; wd_man = 1'b0;
    bus.enable = 1'b1; bus.fifo_req = '0; bus.fifo_empty = '1;
    bus.fifo_oflow = '0; bus.tx_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_chan", 32'(bus.tx_chan), 0);
    chk("rst_start", 32'(bus.tx_start), 0);
    chk("rst_last", 32'(bus.tx_last), 0);
    chk("rst_seq", 32'(bus.seqnum), 0);
    rst_n = 1'b1;
    tick();

    // Round robin over ch 3, 7, 24 with requests held high.
    wd_auto = 1'b1;
    push(3, 0, 4); push(7, 0, 4); push(24, 0, 4); push(3, 0, 4);
    bus.fifo_req[2] = 1'b1;   bus.fifo_req[6] = 1'b1;   bus.fifo_req[23] = 1'b1;
    bus.fifo_empty[2] = 1'b0; bus.fifo_empty[6] = 1'b0; bus.fifo_empty[23] = 1'b0;
    wait_started(4, 2000);
    bus.fifo_req = '0;
    bus.fifo_empty = '1;
    bus.fifo_empty[2] = 1'b0;
    wait_done(4, 500);
    bus.fifo_empty = '1;

    // Idle flush of ch 5 with no request.
    bs = frames_started; bd = frames_done;
    push(5, 0, 4); push(5, 0, 4);
    bus.fifo_empty[4] = 1'b0;
    wait_started(bs + 2, 1000);
    wait_done(bd + 2, 500);
    bus.fifo_empty = '1;
    chk("flush_gap_first", start_cyc[bs] - start_cyc[bs - 1], 102);
    chk("flush_gap_second", start_cyc[bs + 1] - start_cyc[bs], 102);

    // Ch 2 runs dry on its 2nd word.
    wd_auto = 1'b0;
    bs = frames_started; bd = frames_done;
    push(2, 0, 2);
    bus.fifo_req[1] = 1'b1; bus.fifo_empty[1] = 1'b0;
    wait_started(bs + 1, 200);
    bus.fifo_req[1] = 1'b0;
    wd_man = 1'b1; tick();
    wd_man = 1'b0; tick();
    wd_man = 1'b1; bus.fifo_empty[1] = 1'b1; tick();
    wd_man = 1'b0;
    wait_done(bd + 1, 200);

    // Empty frame on ch 6, with tx_busy first holding off the start.
    bs = frames_started; bd = frames_done;
    push(6, 0, 0);
    bus.tx_busy = 1'b1;
    bus.fifo_req[5] = 1'b1;
    repeat (6) tick();
    chk("busy_hold", frames_started - bs, 0);
    bus.tx_busy = 1'b0;
    wait_started(bs + 1, 200);
    bus.fifo_req[5] = 1'b0;
    wait_done(bd + 1, 200);

    // Overflow on ch 9: pulse while idle, then a pulse coincident with ARB.
    wd_auto = 1'b1;
    bus.fifo_oflow[8] = 1'b1; tick();
    bus.fifo_oflow[8] = 1'b0; tick();
    bs = frames_started; bd = frames_done;
    push(9, 1, 4); push(9, 0, 4);
    bus.fifo_req[8] = 1'b1; bus.fifo_empty[8] = 1'b0;
    wait_started(bs + 2, 500);
    bus.fifo_req[8] = 1'b0;
    wait_done(bd + 2, 200);
    bus.fifo_empty[8] = 1'b1;
    repeat (3) tick();
    bs = frames_started; bd = frames_done;
    push(9, 1, 4); push(9, 1, 4);
    bus.fifo_req[8] = 1'b1; bus.fifo_empty[8] = 1'b0;
    tick();
    bus.fifo_oflow[8] = 1'b1; tick();
    bus.fifo_oflow[8] = 1'b0;
    wait_started(bs + 2, 500);
    bus.fifo_req[8] = 1'b0;
    wait_done(bd + 2, 200);
    bus.fifo_empty[8] = 1'b1;

    // Reset mid-DRAIN on ch 11; a stale ch 2 overflow must not survive.
    bus.fifo_oflow[1] = 1'b1; tick();
    bus.fifo_oflow[1] = 1'b0;
    bs = frames_started;
    push(11, 0, 4);
    bus.fifo_req[10] = 1'b1; bus.fifo_empty[10] = 1'b0;
    wait_started(bs + 1, 200);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("arst_grant", 32'(bus.grant), 0);
    chk("arst_chan", 32'(bus.tx_chan), 0);
    chk("arst_start", 32'(bus.tx_start), 0);
    chk("arst_last", 32'(bus.tx_last), 0);
    chk("arst_oflow", 32'(bus.tx_oflow), 0);
    chk("arst_seq", 32'(bus.seqnum), 0);
    sb.delete();
    exp_seq = 0;
    bus.fifo_req[1] = 1'b1; bus.fifo_empty[1] = 1'b0;
    tick(); tick();
    bs = frames_started; bd = frames_done;
    push(2, 0, 4); push(11, 0, 4);
    rst_n = 1'b1;
    wait_started(bs + 2, 500);
    bus.fifo_req = '0;
    bus.fifo_empty[1] = 1'b1;
    wait_done(bd + 2, 200);
    bus.fifo_empty = '1;

    // 256 back-to-back ch 1 frames, with enable dropped during the first.
    bs = frames_started; bd = frames_done;
    for (int i = 0; i < 256; i++) push(1, 0, 4);
    bus.fifo_req[0] = 1'b1; bus.fifo_empty[0] = 1'b0;
    wait_started(bs + 1, 200);
    bus.enable = 1'b0;
    wait_done(bd + 1, 200);
    repeat (20) tick();
    chk("enable_hold", frames_started - bs, 1);
    bus.enable = 1'b1;
    wait_started(bs + 256, 8000);
    bus.fifo_req[0] = 1'b0;
    wait_done(bd + 256, 200);
    bus.fifo_empty = '1;
    repeat (3) tick();
    chk("seq_wrap", 32'(bus.seqnum), 2);
    chk("sb_drained", 32'(sb.size()), 0);
    chk("grant_idle", 32'(bus.grant), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
